// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and defaults for the pipeline hazard / forwarding unit.
package pipe_hazard_unit_pkg;

  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_RADDR    = 5;
  localparam int DEFAULT_DEPTH    = 3;
  localparam int DEFAULT_LOAD_LAT = 2;

  // Widest register address the entry record can carry. Narrower RADDR
  // values are zero-extended, so the unused upper rd bits are constant
  // and get trimmed away.
  localparam int RADDR_MAX = 8;

  // Forwarding select: 0 = register file, k+1 = in-flight entry k.
  localparam int DEFAULT_FWD_SEL_W = $clog2(DEFAULT_DEPTH + 1);

  function automatic int fwd_sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One in-flight instruction past ID.
  typedef struct packed {
    logic                 valid;
    logic [RADDR_MAX-1:0] rd;
    logic                 regwr;
    logic                 is_load;
  } hazard_entry_t;

endpackage

// File: rtl/pipe_fwd_select.sv
// Resolves one source operand: finds the youngest in-flight producer,
// decides whether its result is available yet, and muxes the operand.
module pipe_fwd_select
  import pipe_hazard_unit_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int RADDR    = DEFAULT_RADDR,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
  input  hazard_entry_t [DEPTH-1:0] entries,
  input  logic [RADDR-1:0]          rs,
  input  logic                      rs_used,
  input  logic [XLEN-1:0]           rf_rdata,
  input  logic [DEPTH*XLEN-1:0]     stage_data,
  output logic [XLEN-1:0]           op,
  output logic                      hazard
);

  localparam int SEL_W = fwd_sel_width(DEPTH);

  logic [SEL_W-1:0] sel;
  logic             found;

  // Youngest matching producer wins; a load too young to have data raises a hazard.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sel    = '0;
    found  = 1'b0;
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && rs != '0 && rs_used && entries[k].valid && entries[k].regwr &&
          entries[k].rd == RADDR_MAX'(rs)) begin
        found = 1'b1;
        if (!entries[k].is_load || k >= LOAD_LAT) begin
          sel = SEL_W'(k + 1);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

  // Operand mux: x0 reads as zero, otherwise forward or fall back to the register file.
  always_comb begin
    op = rf_rdata;
    if (rs == '0) begin
      op = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (sel == SEL_W'(k + 1)) begin
          op = stage_data[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight writers after ID, forwards
// operands, stalls on load-use, flushes IF/ID on redirect and counts stalls.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int RADDR    = DEFAULT_RADDR,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int LOAD_LAT = DEFAULT_LOAD_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RADDR-1:0]      id_rs1,
  input  logic [RADDR-1:0]      id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [RADDR-1:0]      id_rd,
  input  logic                  id_regwr,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic [XLEN-1:0]       rf_rdata2,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2,
  output logic                  stall,
  output logic                  flush,
  output logic [31:0]           stall_cnt
);

  // Entry k is the instruction k stages past ID (0 = EX). Kept in flops,
  // not a RAM, because every entry is compared every cycle.
  hazard_entry_t [DEPTH-1:0] entries;
  hazard_entry_t             id_entry;
  logic                      hazard1;
  logic                      hazard2;
  logic                      insert;

  pipe_fwd_select #(
    .XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) u_fwd_rs1 (
    .entries    (entries),
    .rs         (id_rs1),
    .rs_used    (id_rs1_used),
    .rf_rdata   (rf_rdata1),
    .stage_data (stage_data),
    .op         (op1),
    .hazard     (hazard1)
  );

  pipe_fwd_select #(
    .XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) u_fwd_rs2 (
    .entries    (entries),
    .rs         (id_rs2),
    .rs_used    (id_rs2_used),
    .rf_rdata   (rf_rdata2),
    .stage_data (stage_data),
    .op         (op2),
    .hazard     (hazard2)
  );

  // Control: redirect beats stall, and reset suppresses stall.
  always_comb begin
    flush            = ex_redirect;
    stall            = id_valid && (hazard1 || hazard2) && !ex_redirect && !reset;
    insert           = id_valid && !stall && !ex_redirect;
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = RADDR_MAX'(id_rd);
    id_entry.regwr   = id_regwr;
    id_entry.is_load = id_is_load;
  end

  // Shift the in-flight entries every cycle, inserting the ID instruction
  // or a bubble at entry 0, and count stall cycles with saturation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      entries   <= '0;
      stall_cnt <= '0;
    end else begin
      entries[0] <= insert ? id_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
      if (stall && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios followed by
// randomized traffic, all compared against an in-bench instruction-history model.
module tb_pipe_hazard_unit;

  localparam int XLEN     = 32;
  localparam int RADDR    = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;

  logic                  clk;
  logic                  reset;
  logic                  id_valid;
  logic [RADDR-1:0]      id_rs1, id_rs2, id_rd;
  logic                  id_rs1_used, id_rs2_used;
  logic                  id_regwr, id_is_load;
  logic                  ex_redirect;
  logic [XLEN-1:0]       rf_rdata1, rf_rdata2;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic [XLEN-1:0]       op1, op2;
  logic                  stall, flush;
  logic [31:0]           stall_cnt;

  pipe_hazard_unit #(
    .XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwr    (id_regwr),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .stage_data  (stage_data),
    .op1         (op1),
    .op2         (op2),
    .stall       (stall),
    .flush       (flush),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what entered EX on each past cycle, index = age.
  typedef struct {
    bit valid;
    int rd;
    bit regwr;
    bit load;
  } instr_t;

  instr_t      hist[$];
  logic [31:0] exp_cnt;
  int          n_checks;
  int          n_pass;

  logic [XLEN-1:0] obs_op1, obs_op2;
  logic            obs_stall, obs_flush;
  logic [31:0]     obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void clear_hist();
    instr_t empty;
    empty = '{0, 0, 0, 0};
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(empty);
  endfunction

  // Operand value and hazard straight from the forwarding rules.
  function automatic void resolve(input int rs, input bit used, input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] op, output bit haz);
    op  = rf;
    haz = 1'b0;
    if (rs == 0) begin
      op = '0;
      return;
    end
    if (!used) return;
    for (int age = 0; age < hist.size(); age++) begin
      if (hist[age].valid && hist[age].regwr && hist[age].rd == rs) begin
        if (!hist[age].load || age >= LOAD_LAT) op = stage_data[age*XLEN +: XLEN];
        else haz = 1'b1;
        return;
      end
    end
  endfunction

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit ld);
    id_valid    = v;
    id_rs1      = rs1[RADDR-1:0];
    id_rs1_used = u1;
    id_rs2      = rs2[RADDR-1:0];
    id_rs2_used = u2;
    id_rd       = rd[RADDR-1:0];
    id_regwr    = wr;
    id_is_load  = ld;
  endtask

  task automatic rand_data();
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
    for (int i = 0; i < DEPTH; i++) stage_data[i*XLEN +: XLEN] = $urandom;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag);
    logic [XLEN-1:0] e1, e2;
    bit              h1, h2, es, ef;
    instr_t          n;
    @(negedge clk);
    resolve(int'(id_rs1), id_rs1_used, rf_rdata1, e1, h1);
    resolve(int'(id_rs2), id_rs2_used, rf_rdata2, e2, h2);
    es = id_valid && (h1 || h2) && !ex_redirect && !reset;
    ef = ex_redirect;
    obs_op1 = op1; obs_op2 = op2; obs_stall = stall; obs_flush = flush; obs_cnt = stall_cnt;
    check({tag, ".op1"},   op1,       e1);
    check({tag, ".op2"},   op2,       e2);
    check({tag, ".stall"}, stall,     es);
    check({tag, ".flush"}, flush,     ef);
    check({tag, ".cnt"},   stall_cnt, exp_cnt);
    @(posedge clk);
    if (reset) begin
      clear_hist();
      exp_cnt = '0;
    end else begin
      n = '{0, 0, 0, 0};
      if (id_valid && !es && !ef) n = '{1, int'(id_rd), id_regwr, id_is_load};
      hist.push_front(n);
      void'(hist.pop_back());
      if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_hist();
    exp_cnt = '0;
    reset = 1'b1;
    ex_redirect = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rand_data();
    repeat (2) @(posedge clk);
    #1;

    // Reset state: no stall, flush follows redirect, operands from the register file.
    ex_redirect = 1'b1;
    set_id(1, 4, 1, 6, 1, 0, 0, 0);
    step("reset");
    check("reset.stall0", obs_stall, 1'b0);
    check("reset.flush1", obs_flush, 1'b1);
    check("reset.op1rf",  obs_op1,   rf_rdata1);
    reset = 1'b0;
    ex_redirect = 1'b0;

    // ALU chain: addi x5, then a reader of x5 forwards from EX.
    set_id(1, 0, 0, 0, 0, 5, 1, 0); rand_data(); step("alu0");
    set_id(1, 5, 1, 0, 0, 0, 0, 0); rand_data();
    stage_data[0 +: XLEN] = 32'h1234; rf_rdata1 = 32'hDEAD;
    step("alu1");
    check("alu.op1",   obs_op1,   32'h1234);
    check("alu.stall", obs_stall, 1'b0);

    // Load-use: two stall cycles, then forward from the last tracked entry.
    set_id(1, 0, 0, 0, 0, 7, 1, 1); rand_data(); step("lu0");
    set_id(1, 7, 1, 0, 0, 8, 1, 0); rand_data(); step("lu1");
    check("lu.stall_a", obs_stall, 1'b1);
    rand_data(); step("lu2");
    check("lu.stall_b", obs_stall, 1'b1);
    rand_data(); stage_data[2*XLEN +: XLEN] = 32'hCAFE; step("lu3");
    check("lu.stall_c", obs_stall, 1'b0);
    check("lu.op1",     obs_op1,   32'hCAFE);
    check("lu.cnt",     obs_cnt,   32'd2);

    // Double match: youngest writer of x3 wins.
    set_id(1, 0, 0, 0, 0, 3, 1, 0); rand_data(); step("dm0");
    set_id(1, 0, 0, 0, 0, 9, 1, 0); rand_data(); step("dm1");
    set_id(1, 0, 0, 0, 0, 3, 1, 0); rand_data(); step("dm2");
    set_id(1, 0, 0, 3, 1, 0, 0, 0); rand_data();
    stage_data[0 +: XLEN] = 32'hAAAA; stage_data[2*XLEN +: XLEN] = 32'hBBBB;
    step("dm3");
    check("dm.op2", obs_op2, 32'hAAAA);

    // x0 is never forwarded.
    set_id(1, 0, 0, 0, 0, 0, 1, 0); rand_data(); step("x0a");
    set_id(1, 0, 1, 0, 0, 0, 0, 0); rand_data(); rf_rdata1 = 32'h5555; step("x0b");
    check("x0.op1",   obs_op1,   32'h0);
    check("x0.stall", obs_stall, 1'b0);

    // Redirect during a load-use stall: flush wins and ID is not inserted.
    set_id(1, 0, 0, 0, 0, 7, 1, 1); rand_data(); step("rd0");
    set_id(1, 7, 1, 0, 0, 12, 1, 0); ex_redirect = 1'b1; rand_data(); step("rd1");
    check("rd.stall", obs_stall, 1'b0);
    check("rd.flush", obs_flush, 1'b1);
    ex_redirect = 1'b0;
    set_id(1, 12, 1, 0, 0, 0, 0, 0); rand_data(); rf_rdata1 = 32'h1212; step("rd2");
    check("rd.bubble_op1", obs_op1,   32'h1212);
    check("rd.bubble_st",  obs_stall, 1'b0);

    // Reset during a stall drops the pending load.
    set_id(1, 0, 0, 0, 0, 7, 1, 1); rand_data(); step("rs0");
    set_id(1, 7, 1, 0, 0, 0, 0, 0); rand_data(); step("rs1");
    check("rs.stall_pre", obs_stall, 1'b1);
    reset = 1'b1; rand_data(); step("rs2");
    check("rs.stall_in", obs_stall, 1'b0);
    reset = 1'b0; rand_data(); rf_rdata1 = 32'h7777; step("rs3");
    check("rs.op1",   obs_op1,   32'h7777);
    check("rs.stall", obs_stall, 1'b0);
    check("rs.cnt",   obs_cnt,   32'd0);

    // Counter saturation from just below the top.
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    exp_cnt = 32'hFFFF_FFFD;
    for (int r = 0; r < 2; r++) begin
      set_id(1, 0, 0, 0, 0, 7, 1, 1); rand_data(); step("sat_ld");
      set_id(1, 0, 0, 7, 1, 0, 0, 0);
      for (int s = 0; s < LOAD_LAT + 1; s++) begin
        rand_data(); step("sat_use");
      end
    end
    check("sat.cnt", obs_cnt, 32'hFFFF_FFFF);
    reset = 1'b1; rand_data(); step("sat_rst");
    reset = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); rand_data(); step("sat_clr");
    check("sat.cnt0", obs_cnt, 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 49) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 3);
      rand_data();
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32: operand/result data width.
REQ-002 Parameter RADDR, default 5: register address width; register 0 is hardwired zero.
REQ-003 Parameter DEPTH, default 3: tracked in-flight stages after ID (entry 0 = EX ... DEPTH-1 = last stage before regfile write). Legal range 2..8.
REQ-004 Parameter LOAD_LAT, default 2: first entry index at which load data is valid. Legal range 1..DEPTH-1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rs1, id_rs2  in  RADDR each  source register addresses.
REQ-009 id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
REQ-010 id_rd  in  RADDR  destination address.
REQ-011 id_regwr  in  1  the instruction writes rd.
REQ-012 id_is_load  in  1  the instruction is a load.
REQ-013 ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
REQ-014 rf_rdata1, rf_rdata2  in  XLEN each  register-file read data.
REQ-015 stage_data  in  DEPTH*XLEN  result bus of entry k in bits [k*XLEN +: XLEN].
REQ-016 op1, op2  out  XLEN each  resolved operands for the ID instruction.
REQ-017 stall  out  1  hold PC and IF/ID; inject bubble into EX.
REQ-018 flush  out  1  kill IF/ID contents.
REQ-019 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-020 Internal state: DEPTH entries {valid, rd, regwr, is_load}; all entries shift k->k+1 every cycle and entry DEPTH-1 is discarded.
REQ-021 Entry 0 loads the ID instruction when id_valid=1, stall=0 and flush=0; otherwise it loads a bubble (valid=0).
REQ-022 An entry matches operand rsX when valid=1, regwr=1, rd=rsX, rsX!=0 and rsX_used=1.
REQ-023 Priority: the youngest matching entry (lowest k) is the only one considered.
REQ-024 A matching entry is ready when is_load=0, or when is_load=1 and k>=LOAD_LAT.
REQ-025 opX = stage_data[k] for a ready youngest match; opX = rf_rdata for no match; opX = 0 for rsX=0.
REQ-026 stall = id_valid and (youngest match on either operand not ready) and not ex_redirect. It is combinational; stall and opX take effect in the same cycle.
REQ-027 flush = ex_redirect. On redirect the ID instruction is not inserted into entry 0. The existing entries, including the branch in EX, shift normally.
REQ-028 ex_redirect has priority over stall when both conditions hold in the same cycle.
REQ-029 stall_cnt increments by 1 on each cycle with stall=1 and holds at 0xFFFFFFFF.
REQ-030 stall may persist for multiple cycles (at most LOAD_LAT). No combinational path from stall back into the entries other than REQ-021.

Reset
REQ-031 reset clears all entry valid bits and sets stall_cnt=0 on the next rising edge, overriding shift, insert and count.
REQ-032 While reset=1: stall=0 and flush=ex_redirect. opX still follows REQ-025, which yields rf_rdata because no entries are valid.
REQ-033 reset asserted mid-stall discards the pending load entry; the next instruction after release sees no hazards.

Structure
REQ-034 A shared package holds the entry record typedef, the forwarding-select width constant $clog2(DEPTH+1), and the default parameter values.
REQ-035 One sub-module, pipe_fwd_select, resolves one operand (match, priority, ready, mux). It is instantiated twice, for rs1 and rs2.
REQ-036 No memories; all state in flops. Total flops = DEPTH*(RADDR+3)+32.

Verification
REQ-037 ALU chain: addi x5 writes; next cycle ID reads rs1=5 with stage_data[0]=0x1234 -> op1=0x1234, stall=0.
REQ-038 Load-use, DEPTH=3, LOAD_LAT=2: load x7 then ID reads x7 -> stall=1 for 2 cycles, stall_cnt=2; third cycle op=stage_data[2].
REQ-039 Double match: x3 in entry 0 (0xAAAA) and entry 2 (0xBBBB) -> op=0xAAAA.
REQ-040 x0 hazard: entry 0 writes rd=0, ID reads rs1=0 -> op1=0, stall=0.
REQ-041 Redirect during load-use stall -> stall=0, flush=1; entry 0 becomes a bubble next cycle.
REQ-042 Reset during stall, plus stall_cnt forced near 0xFFFFFFFE across 3 stalls -> saturates at 0xFFFFFFFF; reset clears stall_cnt to 0 and all entries to invalid.
